// File: rtl/tty_uart_tx.sv
// TTY character sink: captures core-clock-domain writes into clk_16M, queues them in a
// small FIFO and serialises each character as UART 8N1 (bit 7 always 0) on tx_o.
module tty_uart_tx #(
    parameter int BAUD_DIV = 139,
    parameter int FIFO_AW  = 2
) (
    input  logic               clk_16M,
    input  logic               rst_in,
    input  logic               clk_core_i,
    input  logic               tty_we_i,
    input  logic [6:0]         tty_data_i,
    output logic               tx_o,
    output logic               busy_o,
    output logic               overflow_o,
    output logic [FIFO_AW:0]   level_o,
    output logic [1:0]         dbg_state
);

    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam int                 CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]      BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]   FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Core-domain capture: two flops per signal, plus one history flop on
    // the core clock so its falling edge can be detected.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] we_sync;
    logic       clk_prev;
    logic [6:0] data_s1;
    logic [6:0] data_s2;

    always_ff @(posedge clk_16M or negedge rst_in) begin
        if (!rst_in) begin
            clk_sync <= '0;
            we_sync  <= '0;
            clk_prev <= 1'b0;
            data_s1  <= '0;
            data_s2  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], clk_core_i};
            we_sync  <= {we_sync[0], tty_we_i};
            clk_prev <= clk_sync[1];
            data_s1  <= tty_data_i;
            data_s2  <= data_s1;
        end
    end

    // Falling edge of the core clock is mid core cycle, so data and strobe
    // have long since settled through the same two-flop delay.
    logic push_req;
    assign push_req = clk_prev & ~clk_sync[1] & we_sync[1];

    // ------------------------------------------------------------------
    // FIFO. Push/pop contract: push_req has no back-pressure; it is taken
    // when not full or when the FSM pops in the same cycle, else dropped and
    // flagged. pop is asserted only when level != 0, so it is always valid.
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [6:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW:0]    level;
    logic                pop;
    logic                push_ok;

    assign pop     = (state == IDLE) && (level != '0);
    assign push_ok = push_req && ((level != FULL_LVL) || pop);

    always_ff @(posedge clk_16M) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_s2;
        end
    end

    always_ff @(posedge clk_16M or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push_req && !push_ok) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift_q;
    logic [7:0]    shift_nxt;
    logic          tx_nxt;
    logic          baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk_16M or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift_q  <= shift_nxt;
            tx_o     <= tx_nxt;
        end
    end

    // tx_nxt is the line level for the state being entered, so tx_o is glitch-free.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        tx_nxt    = tx_o;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (pop) begin
                    shift_nxt = {1'b0, mem[rd_ptr]};
                    baud_nxt  = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shift_q[0];
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        shift_nxt = {1'b0, shift_q[7:1]};
                        tx_nxt    = shift_q[1];
                        bit_nxt   = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    assign busy_o    = (state != IDLE) | (level != '0);
    assign level_o   = level;
    assign dbg_state = state;

endmodule

// File: tb/tb_tty_uart_tx.sv
// Directed bench for tty_uart_tx: core-side write driver, UART frame receiver with an
// expected-character queue, and a pass/total report.
module tb_tty_uart_tx;

    localparam int BAUD_DIV = 4;
    localparam int FIFO_AW  = 2;
    localparam int FRAME    = 10 * BAUD_DIV;

    // ---------------- clock / reset ----------------
    logic             clk_16M    = 1'b0;
    logic             rst_in     = 1'b1;
    logic             clk_core_i = 1'b0;
    logic             tty_we_i   = 1'b0;
    logic [6:0]       tty_data_i = '0;
    logic             tx_o;
    logic             busy_o;
    logic             overflow_o;
    logic [FIFO_AW:0] level_o;
    logic [1:0]       dbg_state;

    always #5 clk_16M = ~clk_16M;

    tty_uart_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk_16M   (clk_16M),
        .rst_in    (rst_in),
        .clk_core_i(clk_core_i),
        .tty_we_i  (tty_we_i),
        .tty_data_i(tty_data_i),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .overflow_o(overflow_o),
        .level_o   (level_o),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [6:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART 8N1 with bit 7 = 0, index 0 = start bit
    function automatic logic [9:0] frame_of(input logic [6:0] c);
        return {1'b1, 1'b0, c, 1'b0};
    endfunction

    // ---------------- drivers ----------------
    // One core clock period (called on a negedge of clk_16M): rise with we/data, fall after half.
    task automatic core_cycle(input logic we, input logic [6:0] c, input int half);
        tty_we_i   = we;
        tty_data_i = c;
        clk_core_i = 1'b1;
        repeat (half) @(negedge clk_16M);
        clk_core_i = 1'b0;
        repeat (half) @(negedge clk_16M);
    endtask

    task automatic recv_frame(input int bound, output logic got, output logic [9:0] bits,
                              output logic stable, output int gap, output logic busy_hi);
        got = 1'b0; gap = 0; bits = '0; stable = 1'b1; busy_hi = 1'b1;
        while (gap < bound) begin
            @(negedge clk_16M);
            if (tx_o === 1'b0) begin
                got = 1'b1;
                break;
            end
            gap++;
        end
        if (got) begin
            for (int i = 0; i < 10; i++) begin
                for (int j = 0; j < BAUD_DIV; j++) begin
                    if (i != 0 || j != 0) @(negedge clk_16M);
                    if (j == 0) bits[i] = tx_o;
                    else if (tx_o !== bits[i]) stable = 1'b0;
                    if (busy_o !== 1'b1) busy_hi = 1'b0;
                end
            end
        end
    endtask

    // Receive every queued character; frames after the first must follow after one idle cycle.
    task automatic rx_expected(input int first_bound);
        int         n;
        logic       got;
        logic [9:0] bits;
        logic       stb;
        int         gap;
        logic       bh;
        logic [6:0] e;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            recv_frame((k == 0) ? first_bound : 2 * BAUD_DIV, got, bits, stb, gap, bh);
            chk("rx_got", {31'd0, got}, 32'd1);
            if (!got) break;
            e = exp_q.pop_front();
            chk("rx_frame", {21'd0, stb, bits}, {21'd0, 1'b1, frame_of(e)});
            if (k > 0) chk("rx_gap", gap, 32'd1);
            chk("rx_busy", {31'd0, bh}, 32'd1);
        end
    endtask

    task automatic expect_quiet(input string tag);
        logic       got;
        logic [9:0] bits;
        logic       stb;
        int         gap;
        logic       bh;
        recv_frame(3 * FRAME, got, bits, stb, gap, bh);
        chk(tag, {31'd0, got}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       got;
        logic [9:0] bits;
        logic       stb;
        int         gap;
        logic       bh;
        int         mx;
        logic       found;

        // Reset state
        #2 rst_in = 1'b0;
        #1;
        chk("rst_tx", {31'd0, tx_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        chk("rst_level", level_o, 32'd0);
        repeat (3) @(negedge clk_16M);
        rst_in = 1'b1;
        repeat (5) @(negedge clk_16M);

        // Single 'A' for one core cycle
        fork
            begin
                core_cycle(1'b1, 7'h41, 3);
                core_cycle(1'b0, 7'h00, 3);
            end
            recv_frame(100, got, bits, stb, gap, bh);
        join
        chk("t2_got", {31'd0, got}, 32'd1);
        chk("t2_frame", {21'd0, stb, bits}, {21'd0, 1'b1, 10'b1010000010});
        chk("t2_busy_in_frame", {31'd0, bh}, 32'd1);
        @(negedge clk_16M);
        chk("t2_idle_tx", {31'd0, tx_o}, 32'd1);
        chk("t2_busy_drop", {31'd0, busy_o}, 32'd0);

        // 'H','i' with the write strobe held over two core cycles
        exp_q.push_back(7'h48);
        exp_q.push_back(7'h69);
        mx = 0;
        fork
            begin
                core_cycle(1'b1, 7'h48, 3);
                core_cycle(1'b1, 7'h69, 3);
                core_cycle(1'b0, 7'h00, 3);
            end
            rx_expected(100);
            begin
                repeat (2 * FRAME + 20) begin
                    @(negedge clk_16M);
                    if (int'(level_o) > mx) mx = int'(level_o);
                end
            end
        join
        chk("t3_peak_ok", {31'd0, (mx >= 1 && mx <= 2)}, 32'd1);
        expect_quiet("t3_no_dup");

        // Six quick writes: one in flight, four queued, the sixth dropped
        exp_q.push_back(7'h55);
        exp_q.push_back(7'h2A);
        exp_q.push_back(7'h7F);
        exp_q.push_back(7'h00);
        exp_q.push_back(7'h33);
        fork
            begin
                core_cycle(1'b1, 7'h55, 3);
                core_cycle(1'b1, 7'h2A, 3);
                core_cycle(1'b1, 7'h7F, 3);
                core_cycle(1'b1, 7'h00, 3);
                core_cycle(1'b1, 7'h33, 3);
                core_cycle(1'b1, 7'h4C, 3);
                core_cycle(1'b0, 7'h00, 3);
            end
            rx_expected(100);
        join
        expect_quiet("t4_no_6th");
        chk("t4_ovf_sticky", {31'd0, overflow_o}, 32'd1);
        chk("t4_level_empty", level_o, 32'd0);
        chk("t4_busy_idle", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset mid-run clears the sticky flag without a clock edge
        #2 rst_in = 1'b0;
        #1;
        chk("rst2_ovf", {31'd0, overflow_o}, 32'd0);
        chk("rst2_tx", {31'd0, tx_o}, 32'd1);
        chk("rst2_busy", {31'd0, busy_o}, 32'd0);
        chk("rst2_level", level_o, 32'd0);
        @(negedge clk_16M);
        rst_in = 1'b1;
        repeat (5) @(negedge clk_16M);

        // Push into a full FIFO in the very cycle IDLE pops: accepted
        exp_q.push_back(7'h01);
        exp_q.push_back(7'h02);
        exp_q.push_back(7'h04);
        exp_q.push_back(7'h08);
        exp_q.push_back(7'h10);
        exp_q.push_back(7'h20);
        fork
            begin
                core_cycle(1'b1, 7'h01, 3);
                core_cycle(1'b1, 7'h02, 3);
                core_cycle(1'b1, 7'h04, 3);
                core_cycle(1'b1, 7'h08, 3);
                core_cycle(1'b1, 7'h10, 3);
                core_cycle(1'b0, 7'h00, 6);
                core_cycle(1'b1, 7'h20, 3);
                chk("t6_level_held", level_o, 32'd4);
                core_cycle(1'b0, 7'h00, 3);
            end
            rx_expected(100);
        join
        expect_quiet("t6_no_extra");
        chk("t6_ovf_clear", {31'd0, overflow_o}, 32'd0);

        // Reset during data bit 3 with two characters queued
        found = 1'b0;
        fork
            begin
                core_cycle(1'b1, 7'h41, 3);
                core_cycle(1'b1, 7'h12, 3);
                core_cycle(1'b1, 7'h34, 3);
                tty_we_i = 1'b0;
            end
            begin
                for (int i = 0; i < 100 && !found; i++) begin
                    @(negedge clk_16M);
                    if (tx_o === 1'b0) found = 1'b1;
                end
                if (found) begin
                    repeat (BAUD_DIV + 3 * BAUD_DIV + 1) @(negedge clk_16M);
                    chk("t5_bit3_low", {31'd0, tx_o}, 32'd0);
                    chk("t5_in_data", dbg_state, 32'd2);
                    chk("t5_queued", level_o, 32'd2);
                    rst_in = 1'b0;
                    #1;
                    chk("t5_tx_high", {31'd0, tx_o}, 32'd1);
                    chk("t5_level", level_o, 32'd0);
                    chk("t5_busy", {31'd0, busy_o}, 32'd0);
                    chk("t5_idle", dbg_state, 32'd0);
                end
            end
        join
        chk("t5_start_seen", {31'd0, found}, 32'd1);
        repeat (2) @(negedge clk_16M);
        rst_in = 1'b1;
        expect_quiet("t5_no_frames");
        chk("t5_level_after", level_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
